// File: rtl/ls_exec_unit.sv
// ls_exec_unit
//   Load/store execution unit sitting on the memory side of the load/store
//   reservation station. It takes one dispatched op, forms the address and
//   accesses a private data memory. Loads broadcast their result on the CDB
//   through an arbiter request/grant pair. Stores write the memory. Every op
//   ends with a one-cycle confirma pulse so the station can free its entry.
//
//   Ops are fully serialized: the next op is accepted only after the unit is
//   back in IDLE. A load that follows a store to the same address therefore
//   always sees the stored data.
//
// Parameters
//   ADDR_W   data-memory address width; memory holds 2**ADDR_W 16-bit words
//   MEM_LAT  cycles spent in MEM (1..15)
//
// Configuration macro
//   LSU_SIGNED_OFFSET_EN  defined: offset = sext(Valor1[6:0]) (-64..+63)
//                         undefined: offset = zext(Valor1[6:0]) (0..127)
//   In both cases the address arithmetic wraps modulo 2**ADDR_W.
//
// Ports
//   CLK             in   clock, rising edge
//   CLR             in   asynchronous active-low reset; also clears the memory
//   despacho        in   station has a ready op; sampled only in IDLE
//   ID_in[3:0]      in   station identifier, used as the CDB tag
//   OP_Rd[5:0]      in   [2:0] opcode (011 load, 100 store), [5:3] Rd
//   Valor1[15:0]    in   offset, only [6:0] used
//   Valor2[15:0]    in   base address
//   Valor3[15:0]    in   store data
//   clockInstr[9:0] in   program line of the op
//   busy            out  unit not IDLE
//   confirma        out  one-cycle completion pulse (DONE state)
//   cdb_req         out  load result pending on the CDB (WB state)
//   cdb_grant       in   arbiter grant, looked at only while cdb_req=1
//   CDB_out[19:0]   out  {tag, data} while cdb_req=1, otherwise 0
//   clockInstr_out  out  captured program line of the op in flight
//   state_dbg[2:0]  out  current FSM state encoding
//
// Handshake: cdb_req is a valid that stays high, with CDB_out frozen, until
// the first rising edge at which cdb_grant=1; the transfer happens on that
// edge and cdb_req/CDB_out drop with it. There is no timeout.

module ls_exec_unit #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        despacho,
    input  logic [3:0]  ID_in,
    input  logic [5:0]  OP_Rd,
    input  logic [15:0] Valor1,
    input  logic [15:0] Valor2,
    input  logic [15:0] Valor3,
    input  logic [9:0]  clockInstr,
    output logic        busy,
    output logic        confirma,
    output logic        cdb_req,
    input  logic        cdb_grant,
    output logic [19:0] CDB_out,
    output logic [9:0]  clockInstr_out,
    output logic [2:0]  state_dbg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
    localparam logic [2:0] OPC_LOAD  = 3'b011;
    localparam logic [2:0] OPC_STORE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_MEM  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        id_r;
    logic [2:0]        opc_r;
    logic [6:0]        off_r;
    logic [15:0]       base_r;
    logic [15:0]       data_r;
    logic [9:0]        instr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        cnt_r;
    logic [15:0]       rdata_r;
    logic [15:0]       mem [DEPTH];

    logic              is_load;
    logic              is_store;
    logic [ADDR_W-1:0] off_ext;
    logic              mem_exit;

    // Rd is not needed here (the station tracks it by ID) and only the low
    // seven offset bits and low ADDR_W base bits take part in the address.
    logic unused_bits;
    assign unused_bits = ^{OP_Rd[5:3], Valor1[15:7], base_r};

    assign is_load  = (opc_r == OPC_LOAD);
    assign is_store = (opc_r == OPC_STORE);
    assign mem_exit = (state == S_MEM) && (cnt_r == 4'd0);

`ifdef LSU_SIGNED_OFFSET_EN
    assign off_ext = ADDR_W'($signed(off_r));
`else
    assign off_ext = ADDR_W'(off_r);
`endif

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (despacho) state_nxt = S_ADDR;
            S_ADDR: state_nxt = S_MEM;
            S_MEM: begin
                if (cnt_r == 4'd0) begin
                    // Unsupported opcodes fall through to DONE like a store,
                    // but without touching the memory.
                    state_nxt = is_load ? S_WB : S_DONE;
                end
            end
            S_WB:   if (cdb_grant) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, address, latency counter and memory
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            id_r    <= '0;
            opc_r   <= '0;
            off_r   <= '0;
            base_r  <= '0;
            data_r  <= '0;
            instr_r <= '0;
            addr_r  <= '0;
            cnt_r   <= '0;
            rdata_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (despacho) begin
                        id_r    <= ID_in;
                        opc_r   <= OP_Rd[2:0];
                        off_r   <= Valor1[6:0];
                        base_r  <= Valor2;
                        data_r  <= Valor3;
                        instr_r <= clockInstr;
                    end
                end
                S_ADDR: begin
                    addr_r <= base_r[ADDR_W-1:0] + off_ext;
                    cnt_r  <= CNT_INIT;
                end
                S_MEM: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: ;
            endcase

            if (mem_exit && is_store) begin
                mem[addr_r] <= data_r;
            end
            if (mem_exit && is_load) begin
                rdata_r <= mem[addr_r];
            end
        end
    end

    // Outputs decode straight from the state so reset clears them at once.
    assign busy           = (state != S_IDLE);
    assign confirma       = (state == S_DONE);
    assign cdb_req        = (state == S_WB);
    assign CDB_out        = (state == S_WB) ? {id_r, rdata_r} : 20'h0;
    assign clockInstr_out = instr_r;
    assign state_dbg      = state;

endmodule

// File: tb/tb_ls_exec_unit.sv
// Testbench for ls_exec_unit (ADDR_W=8, MEM_LAT=2).
// Cycle numbering: cycle k is the cycle that starts at edge E0+k, where E0
// is the edge that accepts the op. Outputs are sampled 1 time unit after
// each rising edge; inputs are driven at the same point.

module tb_ls_exec_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        despacho;
    logic [3:0]  ID_in;
    logic [5:0]  OP_Rd;
    logic [15:0] Valor1;
    logic [15:0] Valor2;
    logic [15:0] Valor3;
    logic [9:0]  clockInstr;
    logic        busy;
    logic        confirma;
    logic        cdb_req;
    logic        cdb_grant;
    logic [19:0] CDB_out;
    logic [9:0]  clockInstr_out;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    ls_exec_unit #(.ADDR_W(8), .MEM_LAT(2)) dut (
        .CLK            (CLK),
        .CLR            (CLR),
        .despacho       (despacho),
        .ID_in          (ID_in),
        .OP_Rd          (OP_Rd),
        .Valor1         (Valor1),
        .Valor2         (Valor2),
        .Valor3         (Valor3),
        .clockInstr     (clockInstr),
        .busy           (busy),
        .confirma       (confirma),
        .cdb_req        (cdb_req),
        .cdb_grant      (cdb_grant),
        .CDB_out        (CDB_out),
        .clockInstr_out (clockInstr_out),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- driver ----------------
    // Runs one op as the station would: despacho held until the edge that
    // leaves DONE, grant raised once the request has been up for gdel cycles.
    // Bounded at 40 cycles; conf_cyc stays -1 if confirma never appears.
    task automatic do_op(
        input  logic [5:0]  op,
        input  logic [15:0] v1,
        input  logic [15:0] v2,
        input  logic [15:0] v3,
        input  logic [3:0]  id,
        input  logic [9:0]  instr,
        input  int          gdel,
        output int          conf_cyc,
        output int          conf_cnt,
        output int          req_first,
        output int          req_cnt,
        output logic [19:0] cdb_val,
        output int          cdb_bad,
        output logic [9:0]  instr_seen
    );
        OP_Rd      = op;
        Valor1     = v1;
        Valor2     = v2;
        Valor3     = v3;
        ID_in      = id;
        clockInstr = instr;
        despacho   = 1'b1;
        cdb_grant  = 1'b0;
        conf_cyc   = -1;
        conf_cnt   = 0;
        req_first  = -1;
        req_cnt    = 0;
        cdb_val    = 20'h0;
        cdb_bad    = 0;
        instr_seen = 10'h0;
        @(posedge CLK); #1;
        for (int k = 0; k < 40; k++) begin
            if (k == 0) instr_seen = clockInstr_out;
            if (cdb_req) begin
                if (req_first < 0) begin
                    req_first = k;
                    cdb_val   = CDB_out;
                end else if (CDB_out !== cdb_val) begin
                    cdb_bad++;
                end
                req_cnt++;
            end else if (CDB_out !== 20'h0) begin
                cdb_bad++;
            end
            if (confirma) begin
                conf_cnt++;
                if (conf_cyc < 0) conf_cyc = k;
            end
            if (conf_cyc >= 0 && k == conf_cyc + 1) despacho = 1'b0;
            cdb_grant = cdb_req && (req_cnt > gdel);
            if (conf_cyc >= 0 && k >= conf_cyc + 4) break;
            @(posedge CLK); #1;
        end
        despacho  = 1'b0;
        cdb_grant = 1'b0;
    endtask

    // ---------------- tests ----------------
    int          r_conf, r_cnt, r_rfirst, r_rcnt, r_bad;
    logic [19:0] r_cdb;
    logic [9:0]  r_instr;

    task automatic test_reset();
        CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (confirma !== 1'b0) begin failures++; $display("FAIL reset_confirma got=%b exp=0", confirma); end
        checks++; if (cdb_req !== 1'b0) begin failures++; $display("FAIL reset_cdb_req got=%b exp=0", cdb_req); end
        checks++; if (CDB_out !== 20'h0) begin failures++; $display("FAIL reset_cdb_out got=%h exp=00000", CDB_out); end
        checks++; if (clockInstr_out !== 10'h0) begin failures++; $display("FAIL reset_instr got=%h exp=000", clockInstr_out); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        CLR = 1'b1;
        @(posedge CLK); #1;
        // memory starts cleared
        do_op(6'b001011, 16'h0005, 16'h0010, 16'h0, 4'h5, 10'h001, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_cdb !== 20'h50000) begin failures++; $display("FAIL reset_mem_clear got=%h exp=50000", r_cdb); end
    endtask

    task automatic test_store();
        do_op(6'b000100, 16'h0005, 16'h0010, 16'hBEEF, 4'h3, 10'h123, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_conf !== 3) begin failures++; $display("FAIL store_confirma_cycle got=%0d exp=3", r_conf); end
        checks++; if (r_cnt !== 1) begin failures++; $display("FAIL store_confirma_pulses got=%0d exp=1", r_cnt); end
        checks++; if (r_rcnt !== 0) begin failures++; $display("FAIL store_cdb_req_cycles got=%0d exp=0", r_rcnt); end
        checks++; if (r_bad !== 0) begin failures++; $display("FAIL store_cdb_idle got=%0d exp=0", r_bad); end
        checks++; if (r_instr !== 10'h123) begin failures++; $display("FAIL store_instr_out got=%h exp=123", r_instr); end
    endtask

    task automatic test_load();
        do_op(6'b001011, 16'h0005, 16'h0010, 16'h0, 4'h2, 10'h124, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_rfirst !== 3) begin failures++; $display("FAIL load_req_cycle got=%0d exp=3", r_rfirst); end
        checks++; if (r_cdb !== 20'h2BEEF) begin failures++; $display("FAIL load_cdb got=%h exp=2BEEF", r_cdb); end
        checks++; if (r_conf !== 4) begin failures++; $display("FAIL load_confirma_cycle got=%0d exp=4", r_conf); end
        checks++; if (r_rcnt !== 1) begin failures++; $display("FAIL load_req_cycles got=%0d exp=1", r_rcnt); end
        checks++; if (r_cnt !== 1) begin failures++; $display("FAIL load_confirma_pulses got=%0d exp=1", r_cnt); end
    endtask

    task automatic test_grant_delay();
        do_op(6'b001011, 16'h0005, 16'h0010, 16'h0, 4'h2, 10'h125, 3,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_rcnt !== 4) begin failures++; $display("FAIL gdly_req_cycles got=%0d exp=4", r_rcnt); end
        checks++; if (r_cdb !== 20'h2BEEF) begin failures++; $display("FAIL gdly_cdb got=%h exp=2BEEF", r_cdb); end
        checks++; if (r_bad !== 0) begin failures++; $display("FAIL gdly_cdb_stable got=%0d exp=0", r_bad); end
        checks++; if (r_conf !== 7) begin failures++; $display("FAIL gdly_confirma_cycle got=%0d exp=7", r_conf); end
    endtask

    task automatic test_wrap();
        // 0xFFFE + 3 wraps to 0x01 in either offset mode
        do_op(6'b000100, 16'h0003, 16'hFFFE, 16'h1234, 4'h1, 10'h010, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        do_op(6'b001011, 16'h0000, 16'h0001, 16'h0, 4'h7, 10'h011, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_cdb !== 20'h71234) begin failures++; $display("FAIL wrap_addr01 got=%h exp=71234", r_cdb); end
        // offset 7'h7F: -1 when signed (addr 0x0F), +127 otherwise (addr 0x8F)
        do_op(6'b000100, 16'h007F, 16'h0010, 16'hCAFE, 4'h1, 10'h012, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
`ifdef LSU_SIGNED_OFFSET_EN
        do_op(6'b001011, 16'h0000, 16'h000F, 16'h0, 4'h6, 10'h013, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
`else
        do_op(6'b001011, 16'h0000, 16'h008F, 16'h0, 4'h6, 10'h013, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
`endif
        checks++; if (r_cdb !== 20'h6CAFE) begin failures++; $display("FAIL wrap_offset7f got=%h exp=6CAFE", r_cdb); end
    endtask

    task automatic test_bad_opcode();
        do_op(6'b000001, 16'h0005, 16'h0010, 16'hDEAD, 4'h4, 10'h020, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_conf !== 3) begin failures++; $display("FAIL badop_confirma_cycle got=%0d exp=3", r_conf); end
        checks++; if (r_rcnt !== 0) begin failures++; $display("FAIL badop_cdb_req got=%0d exp=0", r_rcnt); end
        do_op(6'b001011, 16'h0005, 16'h0010, 16'h0, 4'h8, 10'h021, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_cdb !== 20'h8BEEF) begin failures++; $display("FAIL badop_no_write got=%h exp=8BEEF", r_cdb); end
    endtask

    task automatic test_back_to_back();
        int extra_busy;
        // despacho is held through confirma and the DONE exit edge
        do_op(6'b000100, 16'h0001, 16'h0040, 16'h5A5A, 4'h9, 10'h030, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_cnt !== 1) begin failures++; $display("FAIL held_confirma_pulses got=%0d exp=1", r_cnt); end
        extra_busy = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy) extra_busy++;
            @(posedge CLK); #1;
        end
        checks++; if (extra_busy !== 0) begin failures++; $display("FAIL held_no_second_op got=%0d exp=0", extra_busy); end
        // immediately following load of the same word
        do_op(6'b001011, 16'h0001, 16'h0040, 16'h0, 4'hA, 10'h031, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_cdb !== 20'hA5A5A) begin failures++; $display("FAIL b2b_store_load got=%h exp=A5A5A", r_cdb); end
    endtask

    task automatic test_reset_mid_wb();
        int waited;
        OP_Rd = 6'b001011; Valor1 = 16'h0005; Valor2 = 16'h0010; Valor3 = 16'h0;
        ID_in = 4'hB; clockInstr = 10'h040; despacho = 1'b1; cdb_grant = 1'b0;
        @(posedge CLK); #1;
        despacho = 1'b0;
        waited = 0;
        while (!cdb_req && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        checks++; if (cdb_req !== 1'b1) begin failures++; $display("FAIL rstwb_reached_wb got=%b exp=1", cdb_req); end
        CLR = 1'b0;
        #1;
        checks++; if (cdb_req !== 1'b0) begin failures++; $display("FAIL rstwb_cdb_req got=%b exp=0", cdb_req); end
        checks++; if (CDB_out !== 20'h0) begin failures++; $display("FAIL rstwb_cdb_out got=%h exp=00000", CDB_out); end
        checks++; if (confirma !== 1'b0) begin failures++; $display("FAIL rstwb_confirma got=%b exp=0", confirma); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstwb_busy got=%b exp=0", busy); end
        @(posedge CLK); #1;
        CLR = 1'b1;
        @(posedge CLK); #1;
        do_op(6'b001011, 16'h0001, 16'h0040, 16'h0, 4'hC, 10'h041, 0,
              r_conf, r_cnt, r_rfirst, r_rcnt, r_cdb, r_bad, r_instr);
        checks++; if (r_cdb !== 20'hC0000) begin failures++; $display("FAIL rstwb_mem_cleared got=%h exp=C0000", r_cdb); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        CLR = 1'b0; despacho = 1'b0; ID_in = '0; OP_Rd = '0;
        Valor1 = '0; Valor2 = '0; Valor3 = '0; clockInstr = '0; cdb_grant = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_grant_delay();
        test_wrap();
        test_bad_opcode();
        test_back_to_back();
        test_reset_mid_wb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
